// File: rtl/ysyx_22041412_icache.sv
// ysyx_22041412_icache: direct-mapped instruction cache, 16-byte lines, 2^INDEX_W sets.
//   clk, rst (synchronous, active low)       clock and reset
//   valid_i, addr_i, ready_o, data_o         fetch request/response towards the IF stage
//   clean_i, clean_ok_o                      abort of the current request / cache-idle indication
//   mem_req_o, mem_addr_o                    refill read request (held until the last beat)
//   mem_valid_i, mem_data_i, mem_last_i      two-beat refill data, low half first
// Build option: define YSYX_22041412_ICACHE_EN to enable caching. When it is not
// defined, every lookup misses and refills are not stored, so every request goes to memory.
module ysyx_22041412_icache #(
  parameter int unsigned INDEX_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [31:0]  addr_i,
  output logic         ready_o,
  output logic [127:0] data_o,
  input  logic         clean_i,
  output logic         clean_ok_o,
  output logic         mem_req_o,
  output logic [31:0]  mem_addr_o,
  input  logic         mem_valid_i,
  input  logic [63:0]  mem_data_i,
  input  logic         mem_last_i
);

  localparam int unsigned LINE_W  = 128;
  localparam int unsigned BEAT_W  = 64;
  localparam int unsigned LADDR_W = 28;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    REFILL = 3'd2,
    RESP   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t              state;
  logic [LADDR_W-1:0]  line_addr_q;
  logic [BEAT_W-1:0]   beat0_q;

  logic                hit_c;
  logic [LINE_W-1:0]   hit_data_c;
  logic                fill_we_c;
  logic                beat0_we_c;
  logic [LINE_W-1:0]   fill_line_c;
  logic                unused_addr_bits;

  // Byte offset within a line plays no role in a whole-line fetch.
  assign unused_addr_bits = ^addr_i[3:0];

  // A burst is accepted in REFILL and, after an abort, in DRAIN.
  assign fill_we_c   = mem_valid_i && mem_last_i && (state == REFILL || state == DRAIN);
  assign beat0_we_c  = mem_valid_i && !mem_last_i && (state == REFILL || state == DRAIN);
  assign fill_line_c = {mem_data_i, beat0_q};

`ifdef YSYX_22041412_ICACHE_EN
  localparam int unsigned SETS  = 1 << INDEX_W;
  localparam int unsigned TAG_W = 32 - 4 - INDEX_W;

  logic [SETS-1:0]    valid_q;
  logic [TAG_W-1:0]   tag_arr  [SETS];
  logic [LINE_W-1:0]  data_arr [SETS];
  logic [INDEX_W-1:0] index_c;
  logic [TAG_W-1:0]   tag_c;

  assign index_c    = line_addr_q[INDEX_W-1:0];
  assign tag_c      = line_addr_q[LADDR_W-1:INDEX_W];
  assign hit_c      = valid_q[index_c] && (tag_arr[index_c] == tag_c);
  assign hit_data_c = data_arr[index_c];

  // Valid bits are the only storage that needs clearing on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill_we_c) begin
      valid_q[index_c] <= 1'b1;
    end
  end

  // Tag/data arrays: written when a burst completes, including aborted ones.
  always_ff @(posedge clk) begin
    if (fill_we_c) begin
      tag_arr[index_c]  <= tag_c;
      data_arr[index_c] <= fill_line_c;
    end
  end
`else
  assign hit_c      = 1'b0;
  assign hit_data_c = '0;
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      line_addr_q <= '0;
      beat0_q     <= '0;
      ready_o     <= 1'b0;
      data_o      <= '0;
      clean_ok_o  <= 1'b1;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
    end else begin
      if (beat0_we_c) begin
        beat0_q <= mem_data_i;
      end
      case (state)
        IDLE: begin
          if (valid_i && !clean_i) begin
            line_addr_q <= addr_i[31:4];
            clean_ok_o  <= 1'b0;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (clean_i) begin
            clean_ok_o <= 1'b1;
            state      <= IDLE;
          end else if (hit_c) begin
            data_o  <= hit_data_c;
            ready_o <= 1'b1;
            state   <= RESP;
          end else begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= {line_addr_q, 4'b0000};
            state      <= REFILL;
          end
        end
        REFILL: begin
          if (fill_we_c) begin
            mem_req_o <= 1'b0;
            if (clean_i) begin
              // Abort coinciding with the last beat: line kept, no response.
              clean_ok_o <= 1'b1;
              state      <= IDLE;
            end else begin
              data_o  <= fill_line_c;
              ready_o <= 1'b1;
              state   <= RESP;
            end
          end else if (clean_i) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fill_we_c) begin
            mem_req_o  <= 1'b0;
            clean_ok_o <= 1'b1;
            state      <= IDLE;
          end
        end
        RESP: begin
          if (clean_i || !valid_i) begin
            ready_o    <= 1'b0;
            clean_ok_o <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          ready_o    <= 1'b0;
          mem_req_o  <= 1'b0;
          clean_ok_o <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_icache.sv
// Directed testbench for ysyx_22041412_icache; expectations follow the
// YSYX_22041412_ICACHE_EN setting of the build.
module tb_ysyx_22041412_icache;

`ifdef YSYX_22041412_ICACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  localparam logic [63:0]  LA0    = 64'h0000000200000001;
  localparam logic [63:0]  LA1    = 64'h0000000400000003;
  localparam logic [127:0] LINE_A = 128'h00000004000000030000000200000001;
  localparam logic [63:0]  LB0    = 64'h2222222211111111;
  localparam logic [63:0]  LB1    = 64'h4444444433333333;
  localparam logic [127:0] LINE_B = 128'h44444444333333332222222211111111;
  localparam logic [63:0]  LC0    = 64'hCCCC0001CCCC0000;
  localparam logic [63:0]  LC1    = 64'hCCCC0003CCCC0002;
  localparam logic [127:0] LINE_C = 128'hCCCC0003CCCC0002CCCC0001CCCC0000;
  localparam logic [63:0]  LD0    = 64'hDDDD0001DDDD0000;
  localparam logic [63:0]  LE0    = 64'hEEEE0001EEEE0000;
  localparam logic [63:0]  LE1    = 64'hEEEE0003EEEE0002;
  localparam logic [127:0] LINE_E = 128'hEEEE0003EEEE0002EEEE0001EEEE0000;

  localparam logic EXP_REQ_REUSE = !CACHE_ON;
  localparam int   EXP_LAT_REUSE = CACHE_ON ? 2 : 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic [31:0]  addr_i;
  logic         ready_o;
  logic [127:0] data_o;
  logic         clean_i;
  logic         clean_ok_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_valid_i;
  logic [63:0]  mem_data_i;
  logic         mem_last_i;

  int errors = 0;
  int checks = 0;

  logic         sr;
  logic [31:0]  ra;
  logic         st;
  logic [127:0] dt;
  int           lt;
  logic         io;
  logic         rdy_seen;

  ysyx_22041412_icache #(.INDEX_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .addr_i     (addr_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .clean_i    (clean_i),
    .clean_ok_o (clean_ok_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_valid_i(mem_valid_i),
    .mem_data_i (mem_data_i),
    .mem_last_i (mem_last_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Issues one fetch, serves a two-beat refill if requested and reports what it saw.
  // With clean_at_ready the response is aborted via clean_i instead of dropping valid_i.
  task automatic do_fetch(input logic [31:0] a, input logic [63:0] b0, input logic [63:0] b1,
                          input logic clean_at_ready,
                          output logic saw_req, output logic [31:0] req_addr,
                          output logic addr_stable, output logic [127:0] data,
                          output int lat, output logic idle_ok);
    int beat;
    saw_req = 1'b0; req_addr = '0; addr_stable = 1'b1; data = '0;
    lat = -1; beat = 0; idle_ok = 1'b0;
    @(negedge clk);
    valid_i = 1'b1; addr_i = a; clean_i = 1'b0;
    @(posedge clk);
    for (int cnt = 1; cnt <= 40; cnt++) begin
      @(negedge clk);
      mem_valid_i = 1'b0; mem_last_i = 1'b0; mem_data_i = '0;
      if (ready_o) begin
        lat = cnt; data = data_o;
        break;
      end
      if (mem_req_o) begin
        if (!saw_req) begin
          saw_req = 1'b1; req_addr = mem_addr_o;
        end else if (mem_addr_o !== req_addr) begin
          addr_stable = 1'b0;
        end
        if (beat == 0) begin
          mem_valid_i = 1'b1; mem_data_i = b0; beat = 1;
        end else if (beat == 1) begin
          mem_valid_i = 1'b1; mem_last_i = 1'b1; mem_data_i = b1; beat = 2;
        end
      end
    end
    if (clean_at_ready) clean_i = 1'b1;
    else valid_i = 1'b0;
    @(negedge clk);
    idle_ok = clean_ok_o && !ready_o && !mem_req_o;
    if (clean_at_ready) begin
      // valid_i still high together with clean_i: must not start a request
      @(negedge clk);
      idle_ok = idle_ok && clean_ok_o && !ready_o && !mem_req_o;
      @(negedge clk);
      idle_ok = idle_ok && clean_ok_o && !mem_req_o;
      valid_i = 1'b0; clean_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready_o); end
    checks++; if (data_o !== 128'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr_o); end
    checks++; if (clean_ok_o !== 1'b1) begin errors++; $display("FAIL reset_clean_ok got %b exp 1", clean_ok_o); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_fetch();
    do_fetch(32'h80000000, LA0, LA1, 1'b0, sr, ra, st, dt, lt, io);
    checks++; if (sr !== 1'b1) begin errors++; $display("FAIL cold_req got %b exp 1", sr); end
    checks++; if (ra !== 32'h80000000) begin errors++; $display("FAIL cold_addr got %h exp 80000000", ra); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL cold_addr_stable got %b exp 1", st); end
    checks++; if (dt !== LINE_A) begin errors++; $display("FAIL cold_data got %h exp %h", dt, LINE_A); end
    checks++; if (lt !== 4) begin errors++; $display("FAIL cold_latency got %0d exp 4", lt); end
    checks++; if (io !== 1'b1) begin errors++; $display("FAIL cold_idle got %b exp 1", io); end
  endtask

  task automatic test_refetch();
    do_fetch(32'h80000008, LA0, LA1, 1'b0, sr, ra, st, dt, lt, io);
    checks++; if (sr !== EXP_REQ_REUSE) begin errors++; $display("FAIL refetch_req got %b exp %b", sr, EXP_REQ_REUSE); end
    checks++; if (lt !== EXP_LAT_REUSE) begin errors++; $display("FAIL refetch_latency got %0d exp %0d", lt, EXP_LAT_REUSE); end
    checks++; if (dt !== LINE_A) begin errors++; $display("FAIL refetch_data got %h exp %h", dt, LINE_A); end
  endtask

  task automatic test_conflict();
    do_fetch(32'h80000000, LA0, LA1, 1'b0, sr, ra, st, dt, lt, io);
    checks++; if (sr !== EXP_REQ_REUSE) begin errors++; $display("FAIL conflict_a1_req got %b exp %b", sr, EXP_REQ_REUSE); end
    checks++; if (dt !== LINE_A) begin errors++; $display("FAIL conflict_a1_data got %h exp %h", dt, LINE_A); end
    do_fetch(32'h80000200, LB0, LB1, 1'b0, sr, ra, st, dt, lt, io);
    checks++; if (sr !== 1'b1) begin errors++; $display("FAIL conflict_b_req got %b exp 1", sr); end
    checks++; if (ra !== 32'h80000200) begin errors++; $display("FAIL conflict_b_addr got %h exp 80000200", ra); end
    checks++; if (dt !== LINE_B) begin errors++; $display("FAIL conflict_b_data got %h exp %h", dt, LINE_B); end
    do_fetch(32'h80000000, LA0, LA1, 1'b0, sr, ra, st, dt, lt, io);
    checks++; if (sr !== 1'b1) begin errors++; $display("FAIL conflict_a2_req got %b exp 1", sr); end
    checks++; if (ra !== 32'h80000000) begin errors++; $display("FAIL conflict_a2_addr got %h exp 80000000", ra); end
    checks++; if (dt !== LINE_A) begin errors++; $display("FAIL conflict_a2_data got %h exp %h", dt, LINE_A); end
  endtask

  task automatic test_clean_refill();
    rdy_seen = 1'b0;
    @(negedge clk); valid_i = 1'b1; addr_i = 32'h80000010;
    @(posedge clk);
    @(negedge clk); rdy_seen = rdy_seen | ready_o;
    @(negedge clk); rdy_seen = rdy_seen | ready_o;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL clean_refill_req got %b exp 1", mem_req_o); end
    mem_valid_i = 1'b1; mem_last_i = 1'b0; mem_data_i = LC0;
    @(negedge clk); rdy_seen = rdy_seen | ready_o;
    mem_valid_i = 1'b0; mem_data_i = '0; clean_i = 1'b1; valid_i = 1'b0;
    @(negedge clk); rdy_seen = rdy_seen | ready_o;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL drain_req_held got %b exp 1", mem_req_o); end
    checks++; if (clean_ok_o !== 1'b0) begin errors++; $display("FAIL drain_clean_ok got %b exp 0", clean_ok_o); end
    clean_i = 1'b0; mem_valid_i = 1'b1; mem_last_i = 1'b1; mem_data_i = LC1;
    @(negedge clk); rdy_seen = rdy_seen | ready_o;
    mem_valid_i = 1'b0; mem_last_i = 1'b0; mem_data_i = '0;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL drain_req_drop got %b exp 0", mem_req_o); end
    checks++; if (clean_ok_o !== 1'b1) begin errors++; $display("FAIL drain_done_clean_ok got %b exp 1", clean_ok_o); end
    checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL drain_ready_seen got %b exp 0", rdy_seen); end
    do_fetch(32'h80000010, LC0, LC1, 1'b0, sr, ra, st, dt, lt, io);
    checks++; if (sr !== EXP_REQ_REUSE) begin errors++; $display("FAIL after_drain_req got %b exp %b", sr, EXP_REQ_REUSE); end
    checks++; if (lt !== EXP_LAT_REUSE) begin errors++; $display("FAIL after_drain_latency got %0d exp %0d", lt, EXP_LAT_REUSE); end
    checks++; if (dt !== LINE_C) begin errors++; $display("FAIL after_drain_data got %h exp %h", dt, LINE_C); end
  endtask

  task automatic test_reset_refill();
    @(negedge clk); valid_i = 1'b1; addr_i = 32'h80000040;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rst_refill_req got %b exp 1", mem_req_o); end
    mem_valid_i = 1'b1; mem_last_i = 1'b0; mem_data_i = LD0;
    @(negedge clk);
    mem_valid_i = 1'b0; mem_data_i = '0; valid_i = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_refill_req_drop got %b exp 0", mem_req_o); end
    checks++; if (clean_ok_o !== 1'b1) begin errors++; $display("FAIL rst_refill_clean_ok got %b exp 1", clean_ok_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_refill_ready got %b exp 0", ready_o); end
    do_fetch(32'h80000000, LA0, LA1, 1'b0, sr, ra, st, dt, lt, io);
    checks++; if (sr !== 1'b1) begin errors++; $display("FAIL post_rst_req got %b exp 1", sr); end
    checks++; if (lt !== 4) begin errors++; $display("FAIL post_rst_latency got %0d exp 4", lt); end
    checks++; if (dt !== LINE_A) begin errors++; $display("FAIL post_rst_data got %h exp %h", dt, LINE_A); end
  endtask

  task automatic test_clean_lookup();
    @(negedge clk); valid_i = 1'b1; addr_i = 32'h80000300;
    @(posedge clk);
    @(negedge clk); clean_i = 1'b1; valid_i = 1'b0;
    @(negedge clk); clean_i = 1'b0;
    checks++; if (clean_ok_o !== 1'b1) begin errors++; $display("FAIL clean_lookup_ok got %b exp 1", clean_ok_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL clean_lookup_req got %b exp 0", mem_req_o); end
    @(negedge clk);
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL clean_lookup_no_refill got %b exp 0", mem_req_o); end
  endtask

  task automatic test_clean_resp();
    do_fetch(32'h80000000, LA0, LA1, 1'b1, sr, ra, st, dt, lt, io);
    checks++; if (sr !== EXP_REQ_REUSE) begin errors++; $display("FAIL clean_resp_req got %b exp %b", sr, EXP_REQ_REUSE); end
    checks++; if (dt !== LINE_A) begin errors++; $display("FAIL clean_resp_data got %h exp %h", dt, LINE_A); end
    checks++; if (io !== 1'b1) begin errors++; $display("FAIL clean_resp_idle got %b exp 1", io); end
  endtask

  task automatic test_clean_last();
    @(negedge clk); valid_i = 1'b1; addr_i = 32'h80000020;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL clean_last_req got %b exp 1", mem_req_o); end
    mem_valid_i = 1'b1; mem_last_i = 1'b0; mem_data_i = LE0;
    @(negedge clk);
    mem_last_i = 1'b1; mem_data_i = LE1; clean_i = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    mem_valid_i = 1'b0; mem_last_i = 1'b0; mem_data_i = '0; clean_i = 1'b0;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL clean_last_ready got %b exp 0", ready_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL clean_last_req_drop got %b exp 0", mem_req_o); end
    checks++; if (clean_ok_o !== 1'b1) begin errors++; $display("FAIL clean_last_clean_ok got %b exp 1", clean_ok_o); end
    do_fetch(32'h80000020, LE0, LE1, 1'b0, sr, ra, st, dt, lt, io);
    checks++; if (sr !== EXP_REQ_REUSE) begin errors++; $display("FAIL clean_last_refetch_req got %b exp %b", sr, EXP_REQ_REUSE); end
    checks++; if (dt !== LINE_E) begin errors++; $display("FAIL clean_last_refetch_data got %h exp %h", dt, LINE_E); end
  endtask

  initial begin
    rst = 1'b0; valid_i = 1'b0; addr_i = '0; clean_i = 1'b0;
    mem_valid_i = 1'b0; mem_data_i = '0; mem_last_i = 1'b0;
    test_reset();
    test_cold_fetch();
    test_refetch();
    test_conflict();
    test_clean_refill();
    test_reset_refill();
    test_clean_lookup();
    test_clean_resp();
    test_clean_last();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
